fetch_unit: RTL

- Instruction fetch stage directly upstream of the MMU instruction port.
- Holds the fetch PC and issues single-outstanding reads on the imem interface (imem_addr/imem_read/imem_drdy/imem_rdata).
- Buffers returned instructions with their PCs in a small FIFO that feeds decode over a valid/ready handshake.
- Handles redirects (branch/jump) from execute by flushing buffered and in-flight instructions.

---
 rtl/fetch_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly upstream of the MMU instruction
// port. It holds the fetch PC and issues at most one outstanding read on the
// imem interface. Returned words are buffered with their byte PCs in a small
// FIFO that feeds decode over a valid/ready handshake. A redirect from execute
// flushes the buffer and discards any read already in flight.
//
// Parameters
//   RESET_PC   : byte address of the first fetch after reset
//   FIFO_DEPTH : instruction buffer entries (power of two, >= 2)
//   WORD_ADDR  : 1 -> imem_addr = pc >> 2, 0 -> imem_addr = pc
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   redirect_valid  : execute requests a fetch redirect this cycle
//   redirect_pc     : redirect target byte address (bits [1:0] ignored)
//   imem_addr       : fetch address to MMU
//   imem_wdata      : constant zero, the instruction port is read-only
//   imem_read       : fetch request
//   imem_drdy       : MMU read data valid this cycle
//   imem_rdata      : returned instruction word
//   inst_valid      : FIFO head valid
//   inst_ready      : decode accepts the head entry
//   inst_data       : head instruction word
//   inst_pc         : head instruction byte PC
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter bit          WORD_ADDR  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        imem_read,
    input  logic        imem_drdy,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t            state_r;
    logic [31:0]       fetch_pc_r;
    logic [31:0]       drop_pc_r;      // address of the request being discarded
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [31:0]       data_mem_r [FIFO_DEPTH];
    logic [31:0]       pc_mem_r   [FIFO_DEPTH];

    logic              req_s;
    logic              push_s;
    logic              pop_s;
    logic [31:0]       req_pc_s;
    logic [31:0]       redirect_tgt_s;

    // Map a byte PC onto the MMU address format.
    function automatic logic [31:0] to_imem_addr(input logic [31:0] pc);
        if (WORD_ADDR) begin
            return {2'b00, pc[31:2]};
        end else begin
            return pc;
        end
    endfunction

    // Masking keeps the target word aligned while referencing every input bit.
    assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;

    // Request generation: FETCH issues only with free space and no redirect;
    // WAIT and DROP hold the outstanding request until the MMU answers.
    always_comb begin
        req_s    = 1'b0;
        req_pc_s = fetch_pc_r;
        case (state_r)
            ST_FETCH: begin
                req_s    = (count_r < DEPTH_C) && !redirect_valid;
                req_pc_s = fetch_pc_r;
            end
            ST_WAIT: begin
                req_s    = 1'b1;
                req_pc_s = fetch_pc_r;
            end
            ST_DROP: begin
                req_s    = 1'b1;
                req_pc_s = drop_pc_r;
            end
            default: begin
                req_s    = 1'b0;
                req_pc_s = fetch_pc_r;
            end
        endcase
    end

    // A returned word is kept only when it belongs to the current stream.
    assign push_s = req_s && imem_drdy && !redirect_valid && (state_r != ST_DROP);
    assign pop_s  = (count_r != '0) && inst_ready && !redirect_valid;

    // Reset gates the request combinationally so it drops without a clock.
    assign imem_read  = rst_n & req_s;
    assign imem_addr  = to_imem_addr(req_pc_s);
    assign imem_wdata = 32'h0000_0000;
    assign inst_valid = (count_r != '0);
    assign inst_data  = data_mem_r[rd_ptr_r];
    assign inst_pc    = pc_mem_r[rd_ptr_r];

    // Fetch state machine and fetch PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            fetch_pc_r <= RESET_PC;
            drop_pc_r  <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_tgt_s;
            // An un-acked request must still be drained, at its old address.
            if (req_s && !imem_drdy) begin
                state_r   <= ST_DROP;
                drop_pc_r <= req_pc_s;
            end else begin
                state_r   <= ST_FETCH;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (req_s && imem_drdy) begin
                        fetch_pc_r <= fetch_pc_r + 32'd4;
                    end else if (req_s) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (imem_drdy) begin
                        fetch_pc_r <= fetch_pc_r + 32'd4;
                        state_r    <= ST_FETCH;
                    end else begin
                        state_r    <= ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (imem_drdy) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    // Instruction buffer: circular storage, pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= imem_rdata;
                pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
